booth_seq_mult: RTL
===================

BOOTH_SEQ_MULT -- requirements
Module: booth_seq_mult

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits; legal values even and >= 4.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request to begin a multiply; honoured only while ready=1.
REQ-005 SHALL have port sgn  input  1  operand mode: 1 = two's-complement signed, 0 = unsigned.
REQ-006 SHALL have port a  input  WIDTH  multiplicand.
REQ-007 SHALL have port b  input  WIDTH  multiplier, Booth-recoded.
REQ-008 SHALL have port ready  output  1  high while the block can accept start.
REQ-009 SHALL have port done  output  1  one-cycle pulse marking p valid.
REQ-010 SHALL have port p  output  2*WIDTH  product.

Function
REQ-011 SHALL implement a sequential radix-4 Booth multiplier with one Booth digit, in {-2,-1,0,+1,+2}, consumed per RUN cycle.
REQ-012 SHALL use states IDLE, RUN and DONE. IDLE->RUN on start&ready. RUN->DONE after the last digit. DONE->IDLE unconditionally after one cycle.
REQ-013 SHALL drive ready=1 only in IDLE and done=1 only in DONE; both SHALL be registered outputs.
REQ-014 SHALL capture a, b and sgn on the accepting edge; input changes after acceptance SHALL NOT affect the result.
REQ-015 SHALL treat the captured multiplier with an implicit bit b[-1]=0.
REQ-016 Signed mode SHALL sign-extend the operands and SHALL use D=WIDTH/2 digits.
REQ-017 Unsigned mode SHALL zero-extend the multiplier by 2 bits and SHALL use D=WIDTH/2+1 digits, giving correct results for all unsigned operands.
REQ-018 Digit i SHALL be formed as -2*b[2i+1] + b[2i] + b[2i-1]; partial product digit*A SHALL be added at weight 4^i with full 2*WIDTH+2-bit internal precision.
REQ-019 p SHALL equal the exact product truncated to 2*WIDTH bits (exact for all legal operands).
REQ-020 Latency: with accept at edge E0, done SHALL be high from edge E0+D to edge E0+D+1, and ready SHALL return at edge E0+D+1.
REQ-021 p SHALL update only on entry to DONE and SHALL hold until the next result; its value in other states SHALL be the previous product.
REQ-022 start SHALL be ignored in RUN and DONE, with no queuing and no effect on the result in flight.
REQ-023 Back-to-back operation: start held high SHALL be accepted in the first IDLE cycle after DONE, giving a throughput of one result per D+2 cycles.

Reset
REQ-024 rst_n=0 SHALL immediately force state=IDLE, ready=1, done=0 and p=0, and SHALL clear the accumulator, counter and operand registers.
REQ-025 Reset asserted mid-RUN or in DONE SHALL abort the operation with no done pulse; the first accept after release SHALL behave as from power-up.

Configuration
REQ-026 Macro BOOTH_EARLY_TERM_EN SHALL control the early-termination feature.
REQ-027 When BOOTH_EARLY_TERM_EN is defined, RUN SHALL also exit to DONE after digit i if the extended multiplier bits from index 2i+1 upward are all equal; this is a minimum of 1 RUN cycle, and p SHALL be identical to the non-terminated result.
REQ-028 When BOOTH_EARLY_TERM_EN is undefined, RUN SHALL always last exactly D cycles and no zero-detect logic SHALL be synthesised.

Structure
REQ-029 A shared package booth_pkg SHALL hold the state enum (IDLE/RUN/DONE) and the Booth digit-code typedef with fields one, two and neg.
REQ-030 Digit recoding SHALL be a sub-module booth_digit_enc: 3-bit window in, one/two/neg out, combinational, instantiated once.
REQ-031 Digit counter width SHALL be $clog2(WIDTH/2+2).

Verification
REQ-032 WIDTH=8, sgn=1, a=0x80, b=0x80 -> p=0x4000; done exactly 4 cycles after accept.
REQ-033 WIDTH=8, sgn=0, a=0xFF, b=0xFF -> p=0xFE01; done exactly 5 cycles after accept.
REQ-034 WIDTH=8, sgn=1, a=0x07, b=0xFD (-3) -> p=0xFFEB; start pulsed with a=0x01, b=0x01 during RUN -> ignored, p still 0xFFEB.
REQ-035 Accept a=0x12, b=0x34, then assert rst_n=0 at RUN cycle 2 -> p=0, ready=1 and no done pulse; after release, a=0x12, b=0x34 -> p=0x03A8.
REQ-036 With BOOTH_EARLY_TERM_EN, sgn=1, a=0x03, b=0x02 -> p=0x0006 with done 2 cycles after accept; without the macro, the same p with done at 4 cycles.
REQ-037 Random signed and unsigned sweep at WIDTH=8, 16 and 32 with start held high -> every p matches the reference product, with one result per D+2 cycles.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared types for the radix-4 Booth sequential multiplier: FSM states and recoded digit.
// No logic here; latency and backpressure are defined by the users of these types.
// Digit code {neg,two,one}: magnitude 0/1/2, neg selects subtraction.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic neg;
        logic two;
        logic one;
    } digit_t;

endpackage

// File: rtl/booth_digit_enc.sv
// Radix-4 Booth recoder: window {b[2i+1], b[2i], b[2i-1]} to a digit in {-2..+2}.
// Purely combinational, zero latency.
// No handshake; the window is consumed every cycle it is presented.
module booth_digit_enc
    import booth_pkg::*;
(
    input  logic [2:0] win,
    output digit_t     dig
);

    always_comb begin
        dig.one = win[1] ^ win[0];
        dig.two = (win == 3'b011) || (win == 3'b100);
        // 3'b111 is zero, so it must not flag a subtraction
        dig.neg = win[2] & ~(win[1] & win[0]);
    end

endmodule

// File: rtl/booth_seq_mult.sv
// Sequential radix-4 Booth multiplier, signed/unsigned, one digit per RUN cycle (BOOTH_EARLY_TERM_EN: early exit).
// Latency: done pulses D cycles after accept (D = WIDTH/2 signed, WIDTH/2+1 unsigned); ready back one cycle later.
// Backpressure: start is taken only while ready=1; requests in RUN/DONE are dropped, never queued.
module booth_seq_mult
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 sgn,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 ready,
    output logic                 done,
    output logic [2*WIDTH-1:0]   p
);

    localparam int PW = 2*WIDTH + 2;
    localparam int MW = WIDTH + 3;
    localparam int CW = $clog2(WIDTH/2 + 2);
    localparam logic [CW-1:0] LAST_SGN = CW'(WIDTH/2 - 1);
    localparam logic [CW-1:0] LAST_UNS = CW'(WIDTH/2);

    state_t             state, state_nx;
    logic [PW-1:0]      acc, acc_nx;
    logic [PW-1:0]      mcand, mcand_nx;
    logic [MW-1:0]      mplr, mplr_nx;
    logic [CW-1:0]      cnt, cnt_nx;
    logic               sgn_r, sgn_nx;
    logic [2*WIDTH-1:0] p_nx;
    logic [PW-1:0]      pp_mag, pp;
    logic               last;
    digit_t             dig;

    // mplr holds {ext[1:0], b, b[-1]}; the low 3 bits are always the current window
    booth_digit_enc u_enc (
        .win (mplr[2:0]),
        .dig (dig)
    );

    always_comb begin
        pp_mag = dig.two ? {mcand[PW-2:0], 1'b0} : (dig.one ? mcand : '0);
        pp     = dig.neg ? -pp_mag : pp_mag;
`ifdef BOOTH_EARLY_TERM_EN
        // remaining bits all equal => every later digit is zero
        last = (cnt == (sgn_r ? LAST_SGN : LAST_UNS)) ||
               (&mplr[MW-1:2]) || ~(|mplr[MW-1:2]);
`else
        last = (cnt == (sgn_r ? LAST_SGN : LAST_UNS));
`endif
    end

    always_comb begin
        state_nx = state;
        acc_nx   = acc;
        mcand_nx = mcand;
        mplr_nx  = mplr;
        cnt_nx   = cnt;
        sgn_nx   = sgn_r;
        p_nx     = p;
        case (state)
            IDLE: begin
                if (start && ready) begin
                    state_nx = RUN;
                    sgn_nx   = sgn;
                    acc_nx   = '0;
                    cnt_nx   = '0;
                    mcand_nx = {{(PW-WIDTH){sgn & a[WIDTH-1]}}, a};
                    mplr_nx  = {{2{sgn & b[WIDTH-1]}}, b, 1'b0};
                end
            end
            RUN: begin
                acc_nx   = acc + pp;
                mcand_nx = {mcand[PW-3:0], 2'b00};
                mplr_nx  = {{2{mplr[MW-1]}}, mplr[MW-1:2]};
                cnt_nx   = cnt + CW'(1);
                if (last) begin
                    state_nx = DONE;
                    p_nx     = acc_nx[2*WIDTH-1:0];
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ready <= 1'b1;
            done  <= 1'b0;
            p     <= '0;
            acc   <= '0;
            mcand <= '0;
            mplr  <= '0;
            cnt   <= '0;
            sgn_r <= 1'b0;
        end else begin
            state <= state_nx;
            ready <= (state_nx == IDLE);
            done  <= (state_nx == DONE);
            p     <= p_nx;
            acc   <= acc_nx;
            mcand <= mcand_nx;
            mplr  <= mplr_nx;
            cnt   <= cnt_nx;
            sgn_r <= sgn_nx;
        end
    end

endmodule
